// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One BIN_W-bit value per
// start strobe, DIGITS packed BCD digits out after BIN_W+1 cycles, saturating on overflow.
module bin2bcd_seq #(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]      MAX_VAL   = pow10(DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [BIN_W-1:0] shift_q,    shift_d;
  logic [BCD_W-1:0] scratch_q,  scratch_d;
  logic             ovf_q,      ovf_d;
  logic [BCD_W-1:0] bcd_q,      bcd_d;
  logic             overflow_q, overflow_d;
  logic             done_q,     done_d;

  logic [BCD_W-1:0] adj;
  logic [63:0]      bin_ext;

  assign bin_ext = 64'(bin);

  // Add-3 correction on every digit >= 5 so the following doubling carries correctly.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_INIT;
          ovf_d     = (bin_ext > MAX_VAL);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_FINISH;
      end
      S_FINISH: begin
        bcd_d      = ovf_q ? ALL_NINES : scratch_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: an independent cycle model predicts acceptance,
// busy, done timing and the held bcd/overflow values, checked every cycle.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] bin;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        overflow;

  bin2bcd_seq #(.BIN_W(24), .DIGITS(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          cyc        = 0;
  int          busy_end   = -1;
  int          next_free  = 0;
  logic [23:0] hold_bcd   = '0;
  logic        hold_ovf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    if (v > 999999) return 24'h999999;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Compare every observable against the model, once per cycle on the falling edge.
  task automatic monitor();
    logic exp_done;
    exp_t e;
    exp_done = (sb.size() > 0) && (sb[0].due == cyc);
    check("busy", 32'(busy), 32'(cyc <= busy_end));
    check("done", 32'(done), 32'(exp_done));
    check("busy_done_excl", 32'(busy & done), 32'd0);
    if (exp_done) begin
      e        = sb.pop_front();
      hold_bcd = e.bcd;
      hold_ovf = e.ovf;
    end
    check("bcd", 32'(bcd), 32'(hold_bcd));
    check("overflow", 32'(overflow), 32'(hold_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  // Apply inputs for the next rising edge and advance the model accordingly.
  task automatic drive(input logic s, input logic [23:0] b, input logic r);
    int   k;
    exp_t e;
    start = s;
    bin   = b;
    rst_n = r;
    k     = cyc + 1;
    if (!r) begin
      sb.delete();
      if (busy_end > cyc) busy_end = cyc;
      next_free = k + 1;
      hold_bcd  = '0;
      hold_ovf  = 1'b0;
    end else if (s && k >= next_free) begin
      e.bcd     = ref_bcd(int'(b));
      e.ovf     = (b > 24'd999999);
      e.due     = k + 25;
      sb.push_back(e);
      busy_end  = k + 24;
      next_free = k + 26;
    end
  endtask

  task automatic convert(input logic [23:0] b, input int idle);
    drive(1'b1, b, 1'b1);
    step();
    repeat (idle) begin
      drive(1'b0, 24'(b + 24'd1), 1'b1);
      step();
    end
  endtask

  initial begin
    logic [23:0] dir_vals [5];
    dir_vals = '{24'd0, 24'd123456, 24'd999999, 24'd1000000, 24'hFFFFFF};

    drive(1'b0, '0, 1'b0);
    repeat (3) step();
    drive(1'b0, '0, 1'b1);
    step();

    foreach (dir_vals[i]) convert(dir_vals[i], 30);

    // start held high continuously: one conversion every 26 cycles
    repeat (4 * 26 + 3) begin
      drive(1'b1, 24'd42, 1'b1);
      step();
    end
    repeat (30) begin
      drive(1'b0, 24'd0, 1'b1);
      step();
    end

    // start pulses and bin changes while busy must be ignored
    convert(24'd77, 0);
    for (int c = 1; c < 30; c++) begin
      drive((c == 5) || (c == 12), 24'd500 + 24'(c), 1'b1);
      step();
    end

    // reset partway through a conversion aborts it
    convert(24'd654321, 9);
    drive(1'b0, 24'd654321, 1'b0);
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    repeat (30) begin
      drive(1'b0, 24'd0, 1'b1);
      step();
    end
    convert(24'd654321, 30);

    // random sweep, back-to-back
    for (int n = 0; n < 2500; n++) begin
      convert(24'($urandom_range(0, 999999)), 25);
    end
    repeat (30) begin
      drive(1'b0, 24'd0, 1'b1);
      step();
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
